// File: rtl/tp_pkg.sv
// Shared types and sizing for the ping-pong 4x4 block transposer.
package tp_pkg;

    localparam int LANE_W    = 16;
    localparam int LANES     = 4;
    localparam int BLK_CNT_W = 16;

    typedef logic [LANE_W-1:0]       lane_t;
    typedef logic [LANES*LANE_W-1:0] word_t;
    typedef lane_t [LANES-1:0][LANES-1:0] blk_t;
    typedef logic [1:0]              idx_t;

    // Row/column index advance; the 2-bit width gives the 3->0 wrap for free.
    function automatic idx_t idx_next(idx_t i);
        return i + 2'd1;
    endfunction

endpackage

// File: rtl/tp_bank.sv
// One 4x4 element bank: whole-row write port, combinational column read port.
// Contents are deliberately not reset; the full flags in the parent decide
// whether anything in here is meaningful.
module tp_bank
    import tp_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  idx_t  row,
    input  word_t wr_word,
    input  idx_t  col,
    output word_t rd_word
);

    blk_t mem_q;
    blk_t mem_d;

    // Next contents: overwrite one row when written.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                mem_d[row][i] = wr_word[i*LANE_W +: LANE_W];
            end
        end
    end

    // Storage register, no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Column read: output lane r is element [r][col].
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < LANES; r++) begin
            rd_word[r*LANE_W +: LANE_W] = mem_q[r][col];
        end
    end

endmodule

// File: rtl/pp_transposer.sv
// Ping-pong 4x4 block transposer: rows in, columns out, one bank filling
// while the other drains. bank_sel names the bank being written.
module pp_transposer
    import tp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  word_t                in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output word_t                out_data,
    output logic                 bank_sel,
    output logic [BLK_CNT_W-1:0] block_cnt
);

    logic                 bank_sel_q,  bank_sel_d;
    logic [1:0]           full_q,      full_d;
    idx_t                 wr_row_q,    wr_row_d;
    idx_t                 rd_col_q,    rd_col_d;
    logic [BLK_CNT_W-1:0] block_cnt_q, block_cnt_d;

    logic  wb, rb;
    logic  wr_acc, rd_acc, wr_done, rd_done, swap;
    logic  [1:0] bank_we;
    word_t bank_rd [2];

    // Handshake decode; flush suppresses both accepts in its cycle.
    always_comb begin
        wb        = bank_sel_q;
        rb        = ~bank_sel_q;
        in_ready  = ~full_q[wb];
        out_valid = full_q[rb];
        wr_acc    = in_valid & in_ready & ~flush;
        rd_acc    = out_valid & out_ready & ~flush;
        wr_done   = wr_acc & (wr_row_q == 2'd3);
        rd_done   = rd_acc & (rd_col_q == 2'd3);
        // A bank with a complete block can move to the read side as soon as
        // the read side is empty or emptying this very cycle.
        swap      = (full_q[wb] | wr_done) & (~full_q[rb] | rd_done);
        bank_we   = '0;
        bank_we[wb] = wr_acc;
    end

    // Next-state: pointers, full flags, bank select and block counter.
    always_comb begin
        bank_sel_d  = bank_sel_q;
        full_d      = full_q;
        wr_row_d    = wr_row_q;
        rd_col_d    = rd_col_q;
        block_cnt_d = block_cnt_q;

        if (wr_acc) wr_row_d = idx_next(wr_row_q);
        if (rd_acc) rd_col_d = idx_next(rd_col_q);
        if (rd_done) block_cnt_d = block_cnt_q + 1'b1;

        if (swap) begin
            bank_sel_d = ~bank_sel_q;
            full_d[wb] = 1'b1;
            full_d[rb] = 1'b0;
            rd_col_d   = '0;
        end else begin
            full_d[wb] = full_q[wb] | wr_done;
            full_d[rb] = full_q[rb] & ~rd_done;
        end

        if (flush) begin
            bank_sel_d  = 1'b0;
            full_d      = '0;
            wr_row_d    = '0;
            rd_col_d    = '0;
            block_cnt_d = '0;
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_sel_q  <= 1'b0;
            full_q      <= '0;
            wr_row_q    <= '0;
            rd_col_q    <= '0;
            block_cnt_q <= '0;
        end else begin
            bank_sel_q  <= bank_sel_d;
            full_q      <= full_d;
            wr_row_q    <= wr_row_d;
            rd_col_q    <= rd_col_d;
            block_cnt_q <= block_cnt_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        tp_bank u_bank (
            .clk     (clk),
            .we      (bank_we[b]),
            .row     (wr_row_q),
            .wr_word (in_data),
            .col     (rd_col_q),
            .rd_word (bank_rd[b])
        );
    end

    // Column output from the read bank, zero when nothing is presented.
    always_comb begin
        out_data = '0;
        if (out_valid) out_data = bank_rd[rb];
    end

    assign bank_sel  = bank_sel_q;
    assign block_cnt = block_cnt_q;

endmodule

// File: tb/tb_pp_transposer.sv
// Directed bench for pp_transposer. Inputs change on the falling edge,
// outputs are checked 1 ns later, well away from the rising edge.
module tb_pp_transposer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        bank_sel;
    logic [15:0] block_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pp_transposer dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .bank_sel  (bank_sel),
        .block_cnt (block_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Row r of a block whose element [r][c] = base + 4r + c.
    function automatic logic [63:0] row_w(input logic [15:0] base, input int r);
        logic [63:0] w;
        for (int c = 0; c < 4; c++) w[16*c +: 16] = base + 16'(4*r + c);
        return w;
    endfunction

    // Column c of the same block: lane r = base + 4r + c.
    function automatic logic [63:0] col_w(input logic [15:0] base, input int c);
        logic [63:0] w;
        for (int r = 0; r < 4; r++) w[16*r +: 16] = base + 16'(4*r + c);
        return w;
    endfunction

    logic [63:0] lit_cols [4];

    initial begin
        lit_cols[0] = 64'h000C_0008_0004_0000;
        lit_cols[1] = 64'h000D_0009_0005_0001;
        lit_cols[2] = 64'h000E_000A_0006_0002;
        lit_cols[3] = 64'h000F_000B_0007_0003;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_bank_sel",  bank_sel,  0);
        chk("rst_block_cnt", block_cnt, 0);
        rst = 1'b0;

        // Fill then drain, literal column values
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = row_w(16'h0000, r);
            #1;
            chk("fd_in_ready",  in_ready,  1);
            chk("fd_out_valid", out_valid, 0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("fd_valid_rise", out_valid, 1);
        chk("fd_bank_sel",   bank_sel,  1);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            chk("fd_col", out_data, lit_cols[c]);
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("fd_valid_fall", out_valid, 0);
        chk("fd_block_cnt",  block_cnt, 1);
        chk("fd_bank_sel2",  bank_sel,  1);

        // Streaming: three blocks back to back
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            in_valid  = (k < 12);
            in_data   = row_w(16'h0100 + 16'(16*(k/4)), k % 4);
            out_ready = 1'b1;
            #1;
            if (k < 12) chk("st_in_ready", in_ready, 1);
            chk("st_out_valid", out_valid, (k >= 4 && k < 16));
            if (k >= 4 && k < 16)
                chk("st_col", out_data, col_w(16'h0100 + 16'(16*((k-4)/4)), (k-4) % 4));
            else
                chk("st_idle_data", out_data, 0);
            chk("st_bank_sel", bank_sel, 1 ^ (((k/4) > 3 ? 3 : (k/4)) & 1));
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("st_block_cnt", block_cnt, 4);

        // Backpressure: 8 rows with out_ready low, junk rows while stalled
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            in_valid  = (k < 10);
            in_data   = (k < 8) ? row_w((k < 4) ? 16'h0200 : 16'h0210, k % 4)
                                : 64'hDEAD_BEEF_DEAD_BEEF;
            out_ready = (k >= 10);
            #1;
            chk("bp_in_ready",  in_ready,  (k < 8 || k >= 14));
            chk("bp_out_valid", out_valid, (k >= 4 && k < 18));
            if (k >= 4 && k < 10)       chk("bp_hold_col0", out_data, col_w(16'h0200, 0));
            else if (k >= 10 && k < 14) chk("bp_b0_col",    out_data, col_w(16'h0200, k - 10));
            else if (k >= 14 && k < 18) chk("bp_b1_col",    out_data, col_w(16'h0210, k - 14));
            else                        chk("bp_idle_data", out_data, 0);
            chk("bp_bank_sel", bank_sel, (k >= 4 && k < 14));
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp_block_cnt", block_cnt, 6);

        // Simultaneous wr_done and rd_done
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            in_valid  = (k < 4) || (k >= 6 && k < 10);
            in_data   = (k < 4) ? row_w(16'h0300, k) : row_w(16'h0310, (k - 6) & 3);
            out_ready = (k >= 6);
            #1;
            chk("ss_in_ready",  in_ready,  1);
            chk("ss_out_valid", out_valid, (k >= 4 && k < 14));
            if (k >= 4 && k < 6)        chk("ss_hold",  out_data, col_w(16'h0300, 0));
            else if (k >= 6 && k < 10)  chk("ss_a_col", out_data, col_w(16'h0300, k - 6));
            else if (k >= 10 && k < 14) chk("ss_b_col", out_data, col_w(16'h0310, k - 10));
            else                        chk("ss_idle",  out_data, 0);
            chk("ss_bank_sel", bank_sel, (k >= 4 && k < 10));
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("ss_block_cnt", block_cnt, 8);

        // Flush mid-block with in_valid high during the flush cycle
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            flush     = (k == 2);
            in_valid  = (k < 7);
            in_data   = (k < 2)  ? row_w(16'h0400, k) :
                        (k == 2) ? 64'h1111_2222_3333_4444 : row_w(16'h0500, (k - 3) & 3);
            out_ready = 1'b1;
            #1;
            chk("fl_out_valid", out_valid, (k >= 7 && k < 11));
            if (k >= 7 && k < 11) chk("fl_col", out_data, col_w(16'h0500, k - 7));
            chk("fl_bank_sel",  bank_sel,  (k >= 7));
            chk("fl_block_cnt", block_cnt, (k <= 2) ? 8 : (k <= 10) ? 0 : 1);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        // Asynchronous reset in the middle of a drain
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            in_valid  = (k < 4);
            in_data   = row_w(16'h0600, k & 3);
            out_ready = (k == 4 || k == 5);
            #1;
            chk("ar_out_valid", out_valid, (k >= 4));
            if (k >= 4) chk("ar_col", out_data, col_w(16'h0600, k - 4));
            chk("ar_bank_sel", bank_sel, (k < 4));
        end
        chk("ar_cnt_before", block_cnt, 1);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_out_valid_0", out_valid, 0);
        chk("ar_in_ready_1",  in_ready,  1);
        chk("ar_block_cnt_0", block_cnt, 0);
        chk("ar_out_data_0",  out_data,  0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
